// File: rtl/ritc_scan_pkg.sv
// Shared types and defaults for the phase-edge sequencer: FSM states,
// default sizing and edge-polarity encoding.
package ritc_scan_pkg;

  localparam int TIMEOUT_CYCLES_DEF = 1023;
  localparam int STEP_W_DEF         = 16;

  localparam logic EDGE_RISE = 1'b1;
  localparam logic EDGE_FALL = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_PS,
    ST_WAIT_SV,
    ST_CHECK,
    ST_FIN
  } seq_state_t;

  // True when the step from prev_bit to cur_bit is the requested transition.
  function automatic logic is_edge(input logic have_prev, input logic prev_bit,
                                   input logic cur_bit, input logic pol);
    logic rise;
    logic fall;
    rise = (prev_bit == EDGE_FALL) && (cur_bit == EDGE_RISE);
    fall = (prev_bit == EDGE_RISE) && (cur_bit == EDGE_FALL);
    return have_prev && ((pol == EDGE_RISE) ? rise : fall);
  endfunction

endpackage

// File: rtl/ritc_ps_timeout.sv
// Per-step wait timer: loadable down-counter, expired pulses on the last
// enabled cycle of the window.
module ritc_ps_timeout #(
  parameter int CYCLES = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(CYCLES);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Counter sticks at zero afterwards, so this fires once per window.
  assign expired = en && !load && (cnt == CW'(1));

endmodule

// File: rtl/ritc_phase_edge_sequencer.sv
// Steps the DCM/MMCM dynamic phase shift one PSEN at a time and stops on the
// requested transition of the scanner bit, the step limit, a timeout or abort.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for start; results from last run held
// REQ      | one-cycle PSEN pulse, step timer loaded
// WAIT_PS  | waiting for PSDONE (timer running)
// WAIT_SV  | waiting for the scanner's qualified sample (timer reloaded)
// CHECK    | count step, compare sample with previous, decide next step
// FIN      | one-cycle done pulse, back to IDLE
module ritc_phase_edge_sequencer
  import ritc_scan_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int STEP_W         = STEP_W_DEF
) (
  input  logic              CLK,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              dir_i,
  input  logic              edge_pol_i,
  input  logic [STEP_W-1:0] max_steps_i,
  output logic              ps_en_o,
  output logic              ps_incdec_o,
  input  logic              ps_done_i,
  input  logic              scan_valid_i,
  input  logic              scan_bit_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              found_o,
  output logic              timeout_o,
  output logic              aborted_o,
  output logic [STEP_W-1:0] step_count_o,
  output logic [STEP_W-1:0] edge_pos_o
);

  seq_state_t state, state_nxt;

  logic              dir_q;
  logic              pol_q;
  logic [STEP_W-1:0] max_q;
  logic [STEP_W-1:0] step_count;
  logic [STEP_W-1:0] edge_pos;
  logic              found;
  logic              timeout;
  logic              aborted;
  logic              have_prev;
  logic              prev_bit;
  logic              cur_bit;
  logic              abort_pend;

  logic              tmo_load;
  logic              tmo_en;
  logic              tmo_expired;
  logic              tmo_hit;
  logic              capture;
  logic              accept;
  logic              edge_hit;
  logic              abort_now;
  logic [STEP_W-1:0] step_inc;

  assign step_inc  = step_count + 1'b1;
  assign edge_hit  = is_edge(have_prev, prev_bit, cur_bit, pol_q);
  // An abort arriving in the CHECK cycle itself still stops this step.
  assign abort_now = abort_pend | abort_i;
  assign tmo_en    = (state == ST_WAIT_PS) || (state == ST_WAIT_SV);

  ritc_ps_timeout #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (CLK),
    .rst     (rst_i),
    .load    (tmo_load),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  always_ff @(posedge CLK) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tmo_load  = 1'b0;
    tmo_hit   = 1'b0;
    capture   = 1'b0;
    accept    = 1'b0;
    ps_en_o   = 1'b0;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          accept    = 1'b1;
          state_nxt = (max_steps_i == '0) ? ST_FIN : ST_REQ;
        end
      end
      ST_REQ: begin
        busy_o    = 1'b1;
        ps_en_o   = 1'b1;
        tmo_load  = 1'b1;
        state_nxt = ST_WAIT_PS;
      end
      ST_WAIT_PS: begin
        busy_o = 1'b1;
        if (ps_done_i) begin
          if (scan_valid_i) begin
            capture   = 1'b1;
            state_nxt = ST_CHECK;
          end else begin
            tmo_load  = 1'b1;
            state_nxt = ST_WAIT_SV;
          end
        end else if (tmo_expired) begin
          tmo_hit   = 1'b1;
          state_nxt = ST_FIN;
        end
      end
      ST_WAIT_SV: begin
        busy_o = 1'b1;
        if (scan_valid_i) begin
          capture   = 1'b1;
          state_nxt = ST_CHECK;
        end else if (tmo_expired) begin
          tmo_hit   = 1'b1;
          state_nxt = ST_FIN;
        end
      end
      ST_CHECK: begin
        busy_o = 1'b1;
        if (edge_hit || abort_now || (step_inc == max_q)) begin
          state_nxt = ST_FIN;
        end else begin
          state_nxt = ST_REQ;
        end
      end
      ST_FIN: begin
        done_o    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst_i) begin
      dir_q      <= 1'b0;
      pol_q      <= 1'b0;
      max_q      <= '0;
      step_count <= '0;
      edge_pos   <= '0;
      found      <= 1'b0;
      timeout    <= 1'b0;
      aborted    <= 1'b0;
      have_prev  <= 1'b0;
      prev_bit   <= 1'b0;
      cur_bit    <= 1'b0;
      abort_pend <= 1'b0;
    end else begin
      if (accept) begin
        dir_q      <= dir_i;
        pol_q      <= edge_pol_i;
        max_q      <= max_steps_i;
        step_count <= '0;
        edge_pos   <= '0;
        found      <= 1'b0;
        timeout    <= 1'b0;
        aborted    <= 1'b0;
        have_prev  <= 1'b0;
        abort_pend <= 1'b0;
      end
      if (busy_o && abort_i) begin
        abort_pend <= 1'b1;
      end
      if (capture) begin
        cur_bit <= scan_bit_i;
      end
      if (tmo_hit) begin
        timeout <= 1'b1;
      end
      if (state == ST_CHECK) begin
        step_count <= step_inc;
        if (edge_hit) begin
          found    <= 1'b1;
          edge_pos <= step_inc;
        end else begin
          prev_bit  <= cur_bit;
          have_prev <= 1'b1;
          if (abort_now) begin
            aborted <= 1'b1;
          end
        end
      end
    end
  end

  assign ps_incdec_o  = dir_q;
  assign found_o      = found;
  assign timeout_o    = timeout;
  assign aborted_o    = aborted;
  assign step_count_o = step_count;
  assign edge_pos_o   = edge_pos;

endmodule

// File: tb/tb_ritc_phase_edge_sequencer.sv
// Scoreboard bench for ritc_phase_edge_sequencer: a phase-shift/scanner
// responder model, a run-level reference model and a done-triggered checker.
module tb_ritc_phase_edge_sequencer;

  localparam int TMO = 16;
  localparam int SW  = 16;

  logic          CLK = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic          abort_i;
  logic          dir_i = 1'b0;
  logic          edge_pol_i = 1'b0;
  logic [SW-1:0] max_steps_i = '0;
  logic          ps_en_o;
  logic          ps_incdec_o;
  logic          ps_done_i;
  logic          scan_valid_i;
  logic          scan_bit_i;
  logic          busy_o;
  logic          done_o;
  logic          found_o;
  logic          timeout_o;
  logic          aborted_o;
  logic [SW-1:0] step_count_o;
  logic [SW-1:0] edge_pos_o;

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  ritc_phase_edge_sequencer #(
    .TIMEOUT_CYCLES (TMO),
    .STEP_W         (SW)
  ) dut (
    .CLK          (CLK),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .dir_i        (dir_i),
    .edge_pol_i   (edge_pol_i),
    .max_steps_i  (max_steps_i),
    .ps_en_o      (ps_en_o),
    .ps_incdec_o  (ps_incdec_o),
    .ps_done_i    (ps_done_i),
    .scan_valid_i (scan_valid_i),
    .scan_bit_i   (scan_bit_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .found_o      (found_o),
    .timeout_o    (timeout_o),
    .aborted_o    (aborted_o),
    .step_count_o (step_count_o),
    .edge_pos_o   (edge_pos_o)
  );

  typedef struct {
    int found;
    int timeout;
    int aborted;
    int steps;
    int edge_pos;
    int psen;
    int chk_lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  bit bits [1:64];
  int abort_step = 0;
  int drop_ps_step = 0;
  int drop_sv_step = 0;
  int fix_dly = -1;
  int fix_sdly = -1;
  int psen_idx = 0;
  int psen_run_count = 0;
  int last_psen_cyc = 0;
  bit run_dir = 1'b0;

  task automatic chk(input string name, input int act, input int exp_v);
    n_chk++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
  endtask

  // Whole-run outcome from the sample sequence: step k sees bits[k].
  function automatic exp_t model(input bit pol, input int mx, input int ab, input int tstep);
    exp_t e;
    e = '{default: 0};
    for (int k = 1; k <= mx; k++) begin
      e.psen = k;
      if (k == tstep) begin
        e.timeout = 1;
        return e;
      end
      e.steps = k;
      if (k > 1 && bits[k] != bits[k-1] && bits[k] == pol) begin
        e.found    = 1;
        e.edge_pos = k;
        return e;
      end
      if (k == ab) begin
        e.aborted = 1;
        return e;
      end
    end
    return e;
  endfunction

  // Phase-shift port + scanner: PSDONE dly cycles after PSEN, scan-valid sdly later.
  initial begin : responder
    int k, dly, sdly;
    ps_done_i = 1'b0; scan_valid_i = 1'b0; scan_bit_i = 1'b0; abort_i = 1'b0;
    forever begin
      @(negedge CLK);
      if (ps_en_o === 1'b1) begin
        psen_idx++;
        k    = psen_idx;
        dly  = (fix_dly >= 2) ? fix_dly : int'($urandom_range(2, 6));
        sdly = (fix_sdly >= 0) ? fix_sdly : int'($urandom_range(0, 3));
        @(posedge CLK); #1 abort_i = (k == abort_step);
        @(posedge CLK); #1 abort_i = 1'b0;
        repeat (dly - 2) begin @(posedge CLK); #1; end
        if (k != drop_ps_step) begin
          ps_done_i    = 1'b1;
          scan_bit_i   = bits[k];
          scan_valid_i = (sdly == 0) && (k != drop_sv_step);
          @(posedge CLK); #1 ps_done_i = 1'b0; scan_valid_i = 1'b0;
          if (sdly > 0 && k != drop_sv_step) begin
            repeat (sdly - 1) begin @(posedge CLK); #1; end
            scan_valid_i = 1'b1;
            scan_bit_i   = bits[k];
            @(posedge CLK); #1 scan_valid_i = 1'b0;
          end
        end
      end
    end
  end

  initial begin : psen_mon
    forever begin
      @(negedge CLK);
      if (ps_en_o === 1'b1) begin
        if (psen_run_count > 0) chk("psen_gap_ge3", int'((cyc - last_psen_cyc) >= 3), 1);
        chk("ps_incdec", int'(ps_incdec_o), int'(run_dir));
        psen_run_count++;
        last_psen_cyc = cyc;
      end
    end
  end

  initial begin : sb_mon
    exp_t e;
    int   lat;
    forever begin
      @(negedge CLK);
      if (done_o === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", int'(done_o), 0);
        end else begin
          e = sb_q.pop_front();
          chk("found", int'(found_o), e.found);
          chk("timeout", int'(timeout_o), e.timeout);
          chk("aborted", int'(aborted_o), e.aborted);
          chk("step_count", int'(step_count_o), e.steps);
          chk("edge_pos", int'(edge_pos_o), e.edge_pos);
          chk("psen_count", psen_run_count, e.psen);
          chk("busy_low_at_done", int'(busy_o), 0);
          if (e.chk_lat != 0) begin
            lat = cyc - last_psen_cyc;
            chk("timeout_latency_17_18", int'(lat >= TMO + 1 && lat <= TMO + 2), 1);
          end
          @(negedge CLK);
          chk("done_one_cycle", int'(done_o), 0);
        end
      end
    end
  end

  task automatic run(input bit dir, input bit pol, input int mx, input int ab,
                     input int dps, input int dsv, input bit xstart, output int waited);
    exp_t e;
    bit   seen;
    e = model(pol, mx, ab, (dps > 0) ? dps : dsv);
    e.chk_lat = int'((dps > 0) && (e.timeout != 0));
    abort_step = ab; drop_ps_step = dps; drop_sv_step = dsv;
    psen_idx = 0; psen_run_count = 0; run_dir = dir;
    sb_q.push_back(e);
    @(posedge CLK); #1;
    start_i = 1'b1; dir_i = dir; edge_pol_i = pol; max_steps_i = SW'(mx);
    @(posedge CLK); #1;
    start_i = 1'b0; dir_i = ~dir; edge_pol_i = ~pol; max_steps_i = SW'($urandom);
    waited = 0; seen = 1'b0;
    while (!seen && waited < 4000) begin
      @(negedge CLK);
      waited++;
      if (waited == 1 && mx > 0) chk("busy_during_run", int'(busy_o), 1);
      if (waited == 2 && xstart) start_i = 1'b1;
      if (waited == 3) start_i = 1'b0;
      if (done_o === 1'b1) seen = 1'b1;
    end
    start_i = 1'b0;
    chk("run_completed", int'(seen), 1);
    repeat (3) @(posedge CLK);
  endtask

  task automatic set_bits(input bit b1, input bit b2, input bit b3, input bit b4, input bit rest);
    for (int i = 1; i <= 64; i++) bits[i] = rest;
    bits[1] = b1; bits[2] = b2; bits[3] = b3; bits[4] = b4;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int w, wcnt, done_cnt, psen_before, mx, mode, ab, dps, dsv;
    bit dir, pol;

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_ps_en", int'(ps_en_o), 0);
    chk("rst_incdec", int'(ps_incdec_o), 0);
    chk("rst_found", int'(found_o), 0);
    chk("rst_step_count", int'(step_count_o), 0);
    @(posedge CLK); #1 rst_i = 1'b0;

    // Rising edge at step 4
    fix_dly = 5; fix_sdly = 1;
    set_bits(0, 0, 0, 1, 1);
    run(1'b1, 1'b1, 10, 0, 0, 0, 1'b0, w);
    fix_dly = -1; fix_sdly = -1;

    // 0->1 at step 2 must be ignored for a falling search
    set_bits(0, 1, 1, 0, 0);
    run(1'b0, 1'b0, 8, 0, 0, 0, 1'b1, w);

    // Step limit with no edge, then zero-step run
    set_bits(1, 1, 1, 1, 1);
    run(1'b1, 1'b1, 6, 0, 0, 0, 1'b0, w);
    run(1'b1, 1'b0, 0, 0, 0, 0, 1'b0, w);
    chk("max0_done_latency", w, 1);

    // PSDONE never returned
    run(1'b1, 1'b1, 5, 0, 1, 0, 1'b0, w);

    // Abort during step 3, then abort racing an edge at step 3
    set_bits(0, 0, 0, 0, 0);
    run(1'b0, 1'b1, 10, 3, 0, 0, 1'b0, w);
    set_bits(1, 1, 0, 0, 0);
    run(1'b1, 1'b0, 10, 3, 0, 0, 1'b0, w);

    // Reset during WAIT_SV of step 2, with a late scan-valid afterwards
    set_bits(0, 0, 0, 0, 0);
    fix_dly = 3; fix_sdly = 6;
    abort_step = 0; drop_ps_step = 0; drop_sv_step = 0;
    psen_idx = 0; psen_run_count = 0; run_dir = 1'b1;
    @(posedge CLK); #1 start_i = 1'b1; dir_i = 1'b1; edge_pol_i = 1'b1; max_steps_i = SW'(10);
    @(posedge CLK); #1 start_i = 1'b0;
    wcnt = 0;
    while (psen_run_count < 2 && wcnt < 500) begin @(negedge CLK); wcnt++; end
    chk("rst_reached_step2", psen_run_count, 2);
    wcnt = 0;
    while (ps_done_i !== 1'b1 && wcnt < 50) begin @(negedge CLK); wcnt++; end
    chk("rst_saw_psdone", int'(ps_done_i), 1);
    @(posedge CLK); #1;
    @(posedge CLK); #1 rst_i = 1'b1;
    @(posedge CLK); #1 rst_i = 1'b0;
    @(negedge CLK);
    chk("midrst_busy", int'(busy_o), 0);
    chk("midrst_incdec", int'(ps_incdec_o), 0);
    chk("midrst_step_count", int'(step_count_o), 0);
    chk("midrst_ps_en", int'(ps_en_o), 0);
    chk("midrst_flags", int'({found_o, timeout_o, aborted_o, done_o}), 0);
    chk("midrst_edge_pos", int'(edge_pos_o), 0);
    psen_before = psen_run_count;
    done_cnt = 0;
    repeat (20) begin
      @(negedge CLK);
      if (done_o === 1'b1) done_cnt++;
    end
    chk("midrst_no_psen", psen_run_count - psen_before, 0);
    chk("midrst_no_done", done_cnt, 0);
    fix_dly = -1; fix_sdly = -1;
    set_bits(1, 1, 0, 0, 0);
    run(1'b1, 1'b0, 5, 0, 0, 0, 1'b0, w);

    // Randomized runs
    for (int r = 0; r < 40; r++) begin
      mx  = ($urandom_range(0, 14) == 0) ? 0 : int'($urandom_range(1, 20));
      dir = 1'($urandom_range(0, 1));
      pol = 1'($urandom_range(0, 1));
      bits[1] = 1'($urandom_range(0, 1));
      for (int k = 2; k <= 64; k++)
        bits[k] = ($urandom_range(0, 3) == 0) ? ~bits[k-1] : bits[k-1];
      mode = int'($urandom_range(0, 5));
      ab = 0; dps = 0; dsv = 0;
      if (mx > 0) begin
        if (mode == 0) ab = int'($urandom_range(1, mx));
        else if (mode == 1) dps = int'($urandom_range(1, mx));
        else if (mode == 2) dsv = int'($urandom_range(1, mx));
      end
      run(dir, pol, mx, ab, dps, dsv, 1'($urandom_range(0, 1)), w);
    end

    chk("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
